// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_arb_pkg;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEF_DEPTH = 1024;
    localparam logic [DATA_W-1:0] DEF_FILL = 32'h0000_0000;

    typedef enum logic {INIT, RUN} state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Registered bookkeeping for the response issued one cycle after a grant.
    typedef struct packed {
        logic [1:0] own;
        logic       rd;
        logic       err;
    } rsp_tag_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response, control and memory-port signals of mem_arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              req0_valid_i, req1_valid_i;
    logic              req0_ready_o, req1_ready_o;
    logic              req0_we_i,    req1_we_i;
    logic [ADDR_W-1:0] req0_addr_i,  req1_addr_i;
    logic [DATA_W-1:0] req0_wdata_i, req1_wdata_i;
    logic              rsp0_valid_o, rsp1_valid_o;
    logic [DATA_W-1:0] rsp0_rdata_o, rsp1_rdata_o;
    logic              rsp0_err_o,   rsp1_err_o;
    logic              clear_i;
    logic              init_done_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_srst_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  req0_valid_i, req1_valid_i, req0_we_i, req1_we_i,
        input  req0_addr_i, req1_addr_i, req0_wdata_i, req1_wdata_i,
        input  clear_i, mem_rdata_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o, rsp1_rdata_o,
        output rsp0_err_o, rsp1_err_o, init_done_o,
        output mem_we_o, mem_addr_o, mem_wdata_o, mem_srst_o
    );

    modport master (
        output req0_valid_i, req1_valid_i, req0_we_i, req1_we_i,
        output req0_addr_i, req1_addr_i, req0_wdata_i, req1_wdata_i,
        output clear_i, mem_rdata_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o, rsp1_rdata_o,
        input  rsp0_err_o, rsp1_err_o, init_done_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o, mem_srst_o
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer holds the last granted requester.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_c_o
);
    logic ptr_q, ptr_d;
    logic [1:0] gnt;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                gnt = ptr_q ? 2'b01 : 2'b10;
            end else begin
                gnt = valid_i;
            end
            if (gnt != 2'b00) begin
                ptr_d = gnt[1];
            end
        end
    end

    assign grant_c_o = gnt;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Memory initialiser plus two-requester round-robin access arbiter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       DEPTH      = DEF_DEPTH,
    parameter logic [DATA_W-1:0] FILL_VALUE = DEF_FILL
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    mem_arbiter_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    rsp_tag_t          tag_q, tag_d;
    logic [1:0]        valid, grant;
    logic              arb_en;
    mem_cmd_t          sel;
    logic              sel_oor;

    assign arb_en = (state_q == RUN) && !bus.clear_i;
    assign valid  = {bus.req1_valid_i, bus.req0_valid_i};

    rr_arb2 u_rr (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .en_i      (arb_en),
        .valid_i   (valid),
        .grant_c_o (grant)
    );

    assign bus.req0_ready_o = grant[0];
    assign bus.req1_ready_o = grant[1];

    assign sel = grant[1] ? {bus.req1_we_i, bus.req1_addr_i, bus.req1_wdata_i}
                          : {bus.req0_we_i, bus.req0_addr_i, bus.req0_wdata_i};
    assign sel_oor = 32'(sel.addr) >= 32'(DEPTH);

    // Next state, fill counter, response tag and memory command.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        tag_d           = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_srst_o  = 1'b1;
        case (state_q)
            INIT: begin
                // Gated by reset so the port is quiet while arst_ni is held low.
                if (arst_ni) begin
                    bus.mem_we_o    = 1'b1;
                    bus.mem_addr_o  = cnt_q;
                    bus.mem_wdata_o = FILL_VALUE;
                end
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (bus.clear_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (grant != 2'b00) begin
                    tag_d.own = grant;
                    tag_d.rd  = !sel.we;
                    tag_d.err = sel_oor;
                    if (!sel_oor) begin
                        bus.mem_we_o    = sel.we;
                        bus.mem_addr_o  = sel.addr;
                        bus.mem_wdata_o = sel.wdata;
                        bus.mem_srst_o  = 1'b0;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.init_done_o  = (state_q == RUN);
    assign bus.rsp0_valid_o = tag_q.own[0];
    assign bus.rsp1_valid_o = tag_q.own[1];
    assign bus.rsp0_err_o   = tag_q.own[0] && tag_q.err;
    assign bus.rsp1_err_o   = tag_q.own[1] && tag_q.err;
    assign bus.rsp0_rdata_o = (tag_q.own[0] && tag_q.rd && !tag_q.err) ? bus.mem_rdata_i : '0;
    assign bus.rsp1_rdata_o = (tag_q.own[1] && tag_q.rd && !tag_q.err) ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned DEPTH  = 1024;
    localparam logic [31:0] FILL   = 32'h5EED_F111;
    localparam logic [31:0] POISON = 32'hA5A5_5A5A;

    logic clk_i;
    logic arst_ni;
    int   n_vec = 0;
    int   n_err = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.DEPTH(DEPTH), .FILL_VALUE(FILL)) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Read data is meaningless when the port is idled, so return poison then.
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk_i) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o[9:0]] <= bus.mem_wdata_o;
        bus.mem_rdata_i <= bus.mem_srst_o ? POISON : mem[bus.mem_addr_o[9:0]];
    end

    logic [1:0]  rdy;
    logic [49:0] mcmd;
    logic [33:0] rsp0, rsp1;
    assign rdy  = {bus.req1_ready_o, bus.req0_ready_o};
    assign mcmd = {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_srst_o};
    assign rsp0 = {bus.rsp0_valid_o, bus.rsp0_err_o, bus.rsp0_rdata_o};
    assign rsp1 = {bus.rsp1_valid_o, bus.rsp1_err_o, bus.rsp1_rdata_o};

    localparam logic [49:0] MIDLE = {1'b0, 16'h0, 32'h0, 1'b1};

    task automatic idle();
        bus.req0_valid_i = 1'b0; bus.req0_we_i = 1'b0; bus.req0_addr_i = '0; bus.req0_wdata_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_we_i = 1'b0; bus.req1_addr_i = '0; bus.req1_wdata_i = '0;
        bus.clear_i = 1'b0;
    endtask

    // Walk an INIT phase from its first cycle; bad counts cycles off the expected fill pattern.
    task automatic run_init(output int n, output int bad);
        n = 0; bad = 0;
        while (!bus.init_done_o && n < 1100) begin
            if (mcmd !== {1'b1, 16'(n), FILL, 1'b1} || rdy !== 2'b00 ||
                {bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) bad++;
            n++;
            @(negedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        arst_ni = 1'b0;
        idle();
        bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
        #12;
        n_vec++; if (rdy !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", rdy); end
        n_vec++; if ({rsp0, rsp1} !== 68'h0) begin n_err++; $display("FAIL reset_rsp: got %h want 0", {rsp0, rsp1}); end
        n_vec++; if (mcmd !== MIDLE) begin n_err++; $display("FAIL reset_mem: got %h want %h", mcmd, MIDLE); end
        n_vec++; if (bus.init_done_o !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b want 0", bus.init_done_o); end
    endtask

    task automatic test_init();
        int n, bad;
        @(negedge clk_i); arst_ni = 1'b1; #1;
        run_init(n, bad);
        n_vec++; if (n != 1024) begin n_err++; $display("FAIL init_len: got %0d want 1024", n); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL init_pattern: got %0d bad cycles want 0", bad); end
        n_vec++; if ({bus.init_done_o, rdy} !== 3'b101) begin n_err++; $display("FAIL init_first_run: got %b want 101", {bus.init_done_o, rdy}); end
        idle(); #1;
        n_vec++; if (mcmd !== MIDLE) begin n_err++; $display("FAIL run_idle_mem: got %h want %h", mcmd, MIDLE); end
    endtask

    task automatic test_write_read();
        @(negedge clk_i);
        bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1; bus.req0_addr_i = 16'd5; bus.req0_wdata_i = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (rdy !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b want 01", rdy); end
        n_vec++; if (mcmd !== {1'b1, 16'd5, 32'hDEAD_BEEF, 1'b0}) begin n_err++; $display("FAIL wr_mem: got %h", mcmd); end
        @(negedge clk_i); idle();
        bus.req1_valid_i = 1'b1; bus.req1_addr_i = 16'd5;
        #1;
        n_vec++; if (rdy !== 2'b10) begin n_err++; $display("FAIL rd_ready: got %b want 10", rdy); end
        n_vec++; if ({rsp0, rsp1} !== {1'b1, 1'b0, 32'h0, 34'h0}) begin n_err++; $display("FAIL wr_rsp: got %h", {rsp0, rsp1}); end
        n_vec++; if (mcmd !== {1'b0, 16'd5, 32'h0, 1'b0}) begin n_err++; $display("FAIL rd_mem: got %h", mcmd); end
        @(negedge clk_i); idle(); #1;
        n_vec++; if ({rsp0, rsp1} !== {34'h0, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL rd_rsp: got %h want rsp1 DEADBEEF", {rsp0, rsp1}); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            if (i < 6) begin
                bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1;
                bus.req0_addr_i  = 16'(20 + i); bus.req0_wdata_i = 32'h1000_0000 + 32'(i);
                bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b0; bus.req1_addr_i = 16'd5;
            end else begin
                idle();
            end
            #1;
            if (i < 6) begin
                n_vec++;
                if (rdy !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL b2b_grant%0d: got %b", i, rdy); end
                n_vec++;
                if ({bus.mem_we_o, bus.mem_addr_o} !== ((i % 2 == 1) ? {1'b0, 16'd5} : {1'b1, 16'(20 + i)}))
                    begin n_err++; $display("FAIL b2b_mem%0d: got %h", i, {bus.mem_we_o, bus.mem_addr_o}); end
            end
            if (i > 0) begin
                n_vec++;
                if ({rsp0, rsp1} !== (((i - 1) % 2 == 1) ? {34'h0, 1'b1, 1'b0, 32'hDEAD_BEEF} : {1'b1, 1'b0, 32'h0, 34'h0}))
                    begin n_err++; $display("FAIL b2b_rsp%0d: got %h", i, {rsp0, rsp1}); end
            end
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk_i);
        bus.req0_valid_i = 1'b1; bus.req0_addr_i = 16'h0400;
        #1;
        n_vec++; if ({rdy, bus.mem_we_o, bus.mem_srst_o} !== 4'b0101) begin n_err++; $display("FAIL oor_rd_cmd: got %b want 0101", {rdy, bus.mem_we_o, bus.mem_srst_o}); end
        @(negedge clk_i); idle();
        bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b1; bus.req1_addr_i = 16'hFFFF; bus.req1_wdata_i = 32'h1234_5678;
        #1;
        n_vec++; if ({rsp0, rsp1} !== {1'b1, 1'b1, 32'h0, 34'h0}) begin n_err++; $display("FAIL oor_rd_rsp: got %h", {rsp0, rsp1}); end
        n_vec++; if ({rdy, bus.mem_we_o, bus.mem_srst_o} !== 4'b1001) begin n_err++; $display("FAIL oor_wr_cmd: got %b want 1001", {rdy, bus.mem_we_o, bus.mem_srst_o}); end
        @(negedge clk_i); idle(); #1;
        n_vec++; if ({rsp0, rsp1} !== {34'h0, 1'b1, 1'b1, 32'h0}) begin n_err++; $display("FAIL oor_wr_rsp: got %h", {rsp0, rsp1}); end
    endtask

    task automatic test_clear();
        int n, bad;
        @(negedge clk_i);
        bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1; bus.clear_i = 1'b1;
        #1;
        n_vec++; if ({bus.init_done_o, rdy, mcmd} !== {1'b1, 2'b00, MIDLE}) begin n_err++; $display("FAIL clr_cycle: got %h", {bus.init_done_o, rdy, mcmd}); end
        @(negedge clk_i); bus.clear_i = 1'b0; #1;
        n_vec++; if (bus.init_done_o !== 1'b0) begin n_err++; $display("FAIL clr_done_drop: got %b want 0", bus.init_done_o); end
        run_init(n, bad);
        idle();
        n_vec++; if (n != 1024 || bad != 0) begin n_err++; $display("FAIL clr_fill: got %0d cycles %0d bad want 1024 0", n, bad); end
        @(negedge clk_i); bus.req0_valid_i = 1'b1; bus.req0_addr_i = 16'd5; #1;
        @(negedge clk_i); idle(); bus.req1_valid_i = 1'b1; bus.req1_addr_i = 16'd1023; #1;
        n_vec++; if (rsp0 !== {1'b1, 1'b0, FILL}) begin n_err++; $display("FAIL clr_rd5: got %h want %h", rsp0, {2'b10, FILL}); end
        @(negedge clk_i); idle(); #1;
        n_vec++; if (rsp1 !== {1'b1, 1'b0, FILL}) begin n_err++; $display("FAIL clr_rd1023: got %h want %h", rsp1, {2'b10, FILL}); end
    endtask

    task automatic test_reset_mid_txn();
        @(negedge clk_i); bus.req0_valid_i = 1'b1; bus.req0_addr_i = 16'd5; #1;
        @(negedge clk_i); idle(); #1;
        n_vec++; if (bus.rsp0_valid_o !== 1'b1) begin n_err++; $display("FAIL txn_pending: got %b want 1", bus.rsp0_valid_o); end
        bus.req0_valid_i = 1'b1;
        arst_ni = 1'b0; #1;
        n_vec++; if ({rsp0, rsp1, rdy, mcmd, bus.init_done_o} !== {68'h0, 2'b00, MIDLE, 1'b0})
            begin n_err++; $display("FAIL txn_reset: got %h", {rsp0, rsp1, rdy, mcmd, bus.init_done_o}); end
        @(negedge clk_i); arst_ni = 1'b1; idle(); #1;
        n_vec++; if ({mcmd, bus.rsp0_valid_o} !== {1'b1, 16'h0, FILL, 1'b1, 1'b0}) begin n_err++; $display("FAIL txn_restart: got %h", {mcmd, bus.rsp0_valid_o}); end
    endtask

    task automatic test_reset_mid_init();
        int k, n, bad;
        k = 0;
        while (bus.mem_addr_o != 16'd300 && k < 400) begin
            @(negedge clk_i); #1; k++;
        end
        n_vec++; if ({bus.mem_we_o, bus.mem_addr_o} !== {1'b1, 16'd300}) begin n_err++; $display("FAIL mid_init_reach: got %h want 1012c", {bus.mem_we_o, bus.mem_addr_o}); end
        bus.req0_valid_i = 1'b1; bus.req0_addr_i = 16'd5;
        bus.req1_valid_i = 1'b1; bus.req1_addr_i = 16'd1023;
        arst_ni = 1'b0; #1;
        n_vec++; if ({mcmd, rdy, bus.init_done_o} !== {MIDLE, 2'b00, 1'b0}) begin n_err++; $display("FAIL mid_init_reset: got %h", {mcmd, rdy, bus.init_done_o}); end
        @(negedge clk_i); arst_ni = 1'b1; #1;
        run_init(n, bad);
        n_vec++; if (n != 1024 || bad != 0) begin n_err++; $display("FAIL mid_init_restart: got %0d cycles %0d bad want 1024 0", n, bad); end
        n_vec++; if (rdy !== 2'b01) begin n_err++; $display("FAIL ptr_after_reset: got %b want 01", rdy); end
        @(negedge clk_i); #1;
        n_vec++; if ({rdy, rsp0} !== {2'b10, 1'b1, 1'b0, FILL}) begin n_err++; $display("FAIL post_reset_rd0: got %h", {rdy, rsp0}); end
        @(negedge clk_i); idle(); #1;
        n_vec++; if (rsp1 !== {1'b1, 1'b0, FILL}) begin n_err++; $display("FAIL post_reset_rd1: got %h", rsp1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_clear();
        test_reset_mid_txn();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 1024: number of memory words; valid addresses are 0..DEPTH-1.
REQ-002 Parameter FILL_VALUE, default 32'h0000_0000: word written to every address during initialisation.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 arst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid_i  in  1  requester N (N in {0,1}) command valid.
REQ-006 reqN_ready_o  out  1  command from requester N accepted this cycle.
REQ-007 reqN_we_i  in  1  1 = write, 0 = read.
REQ-008 reqN_addr_i  in  16  word address.
REQ-009 reqN_wdata_i  in  32  write data.
REQ-010 rspN_valid_o  out  1  response for requester N; single-cycle pulse, no backpressure.
REQ-011 rspN_rdata_o  out  32  read data; 0 for write or error responses.
REQ-012 rspN_err_o  out  1  address out of range.
REQ-013 clear_i  in  1  in RUN, request a full re-initialisation.
REQ-014 init_done_o  out  1  high while in RUN.
REQ-015 mem_we_o, mem_addr_o[15:0], mem_wdata_o[31:0], mem_srst_o  out  memory command port.
REQ-016 mem_rdata_i  in  32  memory read data, valid in the cycle after the read command.

Function
REQ-017 Two states: INIT, RUN. Reset enters INIT with fill counter 0.
REQ-018 INIT: each cycle drive mem_we_o=1, mem_addr_o=counter, mem_wdata_o=FILL_VALUE, mem_srst_o=1; increment counter; after address DEPTH-1 go to RUN. INIT lasts exactly DEPTH cycles.
REQ-019 INIT: both reqN_ready_o=0; no responses except those owed from the last RUN cycle.
REQ-020 RUN with clear_i=1: no grant that cycle; next state INIT with counter reset to 0.
REQ-021 RUN with clear_i=0: grant at most one requester per cycle; reqN_ready_o is combinational from valids and the priority pointer, and is high only for the granted requester.
REQ-022 Round-robin: if both are valid, grant the requester other than the last granted; if one is valid, grant it. The pointer updates only on a grant.
REQ-023 Granted in-range command: mem_we_o=reqN_we_i, mem_addr_o=reqN_addr_i, mem_wdata_o=reqN_wdata_i, mem_srst_o=0, all in the same cycle.
REQ-024 Granted command with addr >= DEPTH: accepted, but mem_we_o=0 and mem_srst_o=1; response has err=1 and rdata=0.
REQ-025 No grant in RUN: mem_we_o=0, mem_srst_o=1, mem_addr_o=0, mem_wdata_o=0.
REQ-026 Response latency 1: rspN_valid_o pulses in the cycle after the handshake, driven by registered owner, type and error bits.
REQ-027 Read response data: rspN_rdata_o=mem_rdata_i. Write response: rdata=0, err=0. The non-owner's response outputs are all 0.
REQ-028 A new grant is allowed every cycle (back-to-back), including in the cycle a response is issued.

Reset
REQ-029 While arst_ni=0: reqN_ready_o=0, rspN_valid_o=0, rspN_rdata_o=0, rspN_err_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_srst_o=1, init_done_o=0, pointer=1 (requester 0 wins first).
REQ-030 Reset asserted mid-INIT or mid-transaction: pending response is discarded; after release INIT restarts at address 0.

Structure
REQ-031 Shared package mem_arb_pkg: state enum {INIT, RUN}, ADDR_W=16, DATA_W=32, default DEPTH and FILL_VALUE.
REQ-032 One sub-module, rr_arb2: 2-way round-robin grant with a registered last-grant pointer.

Verification
REQ-033 Reset release, DEPTH=1024 -> exactly 1024 INIT write cycles on addresses 0..1023 with FILL_VALUE, then init_done_o=1 and no ready earlier.
REQ-034 req0 write addr 5 data 32'hDEADBEEF, then req1 read addr 5 -> rsp1_rdata_o=32'hDEADBEEF one cycle after the read handshake.
REQ-035 Both valid every cycle for 6 cycles -> grants 0,1,0,1,0,1; each response routed to the correct requester.
REQ-036 req0 read addr 16'h0400 -> rsp0_err_o=1, rdata=0, and no mem_we_o pulse.
REQ-037 clear_i=1 in RUN with both valid -> no grant that cycle, init_done_o drops, 1024 fill writes, then reads return FILL_VALUE.
REQ-038 arst_ni pulsed low at INIT address 300 -> outputs take reset values immediately; after release INIT restarts at 0.
